mac_array_ctrl: RTL

Sequencer for the `mac_col` systolic array. It drives the array's 2-bit instruction stream `{execute, load}` and the read side of the shared query/key SRAM. For each job it streams key vectors to preload every column, then streams query vectors for execution. During execution it throttles issue against the output FIFO's almost-full flag, and it signals completion once the last result has cleared the array pipeline.

---
 rtl/mac_array_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the mac_col array: key preload, throttled query execute, drain, done pulse.
// All outputs registered; inst trails each SRAM read by one cycle; ofifo_afull is registered, so a stall takes effect two edges after it rises.
module mac_array_ctrl #(
  parameter int col       = 8,
  parameter int addr_bw   = 6,
  parameter int load_len  = 10,
  parameter int drain_len = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] key_base,
  input  logic [addr_bw-1:0] q_base,
  input  logic [addr_bw-1:0] q_len,
  input  logic               ofifo_afull,
  output logic               mem_rd_en,
  output logic [addr_bw-1:0] mem_addr,
  output logic [1:0]         inst,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, DRAIN, DONE} state_t;

  localparam int cnt_w = 16;

  // The drain window must at least cover the skew across the column chain.
  if (load_len < 1 || drain_len < col) begin : g_param_check
    $error("mac_array_ctrl: load_len must be >= 1 and drain_len >= col");
  end

  state_t             state;
  logic [cnt_w-1:0]   cnt;
  logic [addr_bw-1:0] issued;
  logic [addr_bw-1:0] key_base_q;
  logic [addr_bw-1:0] q_base_q;
  logic [addr_bw-1:0] q_len_q;
  logic               afull_q;
  logic               rd_exec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      issued     <= '0;
      key_base_q <= '0;
      q_base_q   <= '0;
      q_len_q    <= '0;
      afull_q    <= 1'b0;
      rd_exec    <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      inst       <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // inst reflects the read issued on the previous edge, once the SRAM data is valid.
      inst      <= {mem_rd_en & rd_exec, mem_rd_en & ~rd_exec};
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      afull_q   <= ofifo_afull;

      case (state)
        IDLE: begin
          busy   <= start;
          cnt    <= '0;
          issued <= '0;
          if (start) begin
            key_base_q <= key_base;
            q_base_q   <= q_base;
            q_len_q    <= q_len;
            state      <= LOAD;
          end
        end

        LOAD: begin
          mem_rd_en <= 1'b1;
          rd_exec   <= 1'b0;
          mem_addr  <= key_base_q + addr_bw'(cnt);
          cnt       <= cnt + 1'b1;
          if (cnt == cnt_w'(load_len - 1)) begin
            cnt   <= '0;
            state <= (q_len_q == '0) ? DRAIN : EXEC;
          end
        end

        EXEC: begin
          if (!afull_q) begin
            mem_rd_en <= 1'b1;
            rd_exec   <= 1'b1;
            mem_addr  <= q_base_q + issued;
            issued    <= issued + 1'b1;
            if (issued + 1'b1 == q_len_q) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt == cnt_w'(drain_len - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end
        end

        DONE: begin
          // busy stays high through the done cycle and drops from IDLE next edge.
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
